// File: rtl/calc_ctrl.sv
// calc_ctrl: button conditioning, 4x4 keypad cursor and entry/compute FSM feeding the LCD pixel stage.
// Optional macro CALC_DEBOUNCE_EN inserts per-button debounce counters after the synchronizers.
module calc_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MAX_OPERAND     = 9999
) (
    input  logic        clk_in,
    input  logic        sys_rst_n,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_ok,
    output logic [3:0]  cursor_x,
    output logic [3:0]  cursor_y,
    output logic [7:0]  input_val,
    output logic [7:0]  op_char,
    output logic [15:0] result,
    output logic        calc_done,
    output logic        busy,
    output logic        ovf
);

    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_OP      = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_CALC    = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [7:0]  CH_ADD  = 8'h2B;
    localparam logic [7:0]  CH_SUB  = 8'h2D;
    localparam logic [7:0]  CH_MUL  = 8'h2A;
    localparam logic [7:0]  CH_ZERO = 8'h30;
    localparam logic [19:0] MAX_W   = 20'(MAX_OPERAND);
    localparam logic [15:0] MAX_16  = 16'(MAX_OPERAND);

    // bit order: {ok, up, down, left, right}
    logic [4:0] btn_raw_s;
    logic [4:0] sync1_d, sync1_q, sync2_d, sync2_q;
    logic [4:0] deb_level_s;
    logic [4:0] deb_prev_d, deb_prev_q;
    logic [4:0] pulse_s;

    assign btn_raw_s = {btn_ok, btn_up, btn_down, btn_left, btn_right};

    // Synchronizer chain and edge-detect history next values
    always_comb begin
        sync1_d    = btn_raw_s;
        sync2_d    = sync1_q;
        deb_prev_d = deb_level_s;
    end

    // Synchronizer and edge-detect history registers
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_q    <= 5'b00000;
            sync2_q    <= 5'b00000;
            deb_prev_q <= 5'b00000;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_prev_q <= deb_prev_d;
        end
    end

`ifdef CALC_DEBOUNCE_EN
    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    for (genvar i = 0; i < 5; i++) begin : g_deb
        logic [CNT_W-1:0] cnt_d, cnt_q;
        logic             lvl_d, lvl_q;

        // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_comb begin
            cnt_d = cnt_q;
            lvl_d = lvl_q;
            if (sync2_q[i] == lvl_q) begin
                cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_LAST) begin
                lvl_d = sync2_q[i];
                cnt_d = {CNT_W{1'b0}};
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Debounce counter and accepted level
        always_ff @(posedge clk_in or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                cnt_q <= {CNT_W{1'b0}};
                lvl_q <= 1'b0;
            end else begin
                cnt_q <= cnt_d;
                lvl_q <= lvl_d;
            end
        end

        assign deb_level_s[i] = lvl_q;
    end
`else
    assign deb_level_s = sync2_q;
`endif

    assign pulse_s = deb_level_s & ~deb_prev_q;

    logic       ok_s;
    logic [1:0] cur_x_d, cur_x_q, cur_y_d, cur_y_q;

    assign ok_s = pulse_s[4];

    // Cursor movement; the priority chain drops lower-priority same-cycle presses
    always_comb begin
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (pulse_s[4]) begin
            cur_x_d = cur_x_q;
        end else if (pulse_s[3]) begin
            cur_y_d = cur_y_q - 2'd1;
        end else if (pulse_s[2]) begin
            cur_y_d = cur_y_q + 2'd1;
        end else if (pulse_s[1]) begin
            cur_x_d = cur_x_q - 2'd1;
        end else if (pulse_s[0]) begin
            cur_x_d = cur_x_q + 2'd1;
        end else begin
            cur_y_d = cur_y_q;
        end
    end

    // Cursor registers
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cur_x_q <= 2'd0;
            cur_y_q <= 2'd0;
        end else begin
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;
        end
    end

    logic [3:0] key_digit_s;
    logic       key_is_digit_s, key_is_op_s, key_is_eq_s, key_is_clr_s;
    logic [7:0] key_op_s;

    // Keypad map indexed by {row, col}
    always_comb begin
        key_digit_s    = 4'd0;
        key_is_digit_s = 1'b0;
        key_is_op_s    = 1'b0;
        key_op_s       = 8'h00;
        key_is_eq_s    = 1'b0;
        key_is_clr_s   = 1'b0;
        case ({cur_y_q, cur_x_q})
            4'h0: begin key_is_digit_s = 1'b1; key_digit_s = 4'd1; end
            4'h1: begin key_is_digit_s = 1'b1; key_digit_s = 4'd2; end
            4'h2: begin key_is_digit_s = 1'b1; key_digit_s = 4'd3; end
            4'h3: begin key_is_op_s = 1'b1; key_op_s = CH_ADD; end
            4'h4: begin key_is_digit_s = 1'b1; key_digit_s = 4'd4; end
            4'h5: begin key_is_digit_s = 1'b1; key_digit_s = 4'd5; end
            4'h6: begin key_is_digit_s = 1'b1; key_digit_s = 4'd6; end
            4'h7: begin key_is_op_s = 1'b1; key_op_s = CH_SUB; end
            4'h8: begin key_is_digit_s = 1'b1; key_digit_s = 4'd7; end
            4'h9: begin key_is_digit_s = 1'b1; key_digit_s = 4'd8; end
            4'hA: begin key_is_digit_s = 1'b1; key_digit_s = 4'd9; end
            4'hB: begin key_is_op_s = 1'b1; key_op_s = CH_MUL; end
            4'hC: key_is_clr_s = 1'b1;
            4'hD: begin key_is_digit_s = 1'b1; key_digit_s = 4'd0; end
            4'hE: key_is_eq_s = 1'b1;
            default: key_is_eq_s = 1'b0;
        endcase
    end

    state_t      state_d, state_q;
    logic [15:0] a_d, a_q, b_d, b_q;
    logic [7:0]  input_val_d, input_val_q, op_char_d, op_char_q;
    logic [15:0] result_d, result_q;
    logic        calc_done_d, calc_done_q, busy_d, busy_q, ovf_d, ovf_q;
    logic [31:0] acc_d, acc_q, mcand_d, mcand_q;
    logic [15:0] mplier_d, mplier_q;
    logic [3:0]  iter_d, iter_q;

    logic [19:0] a_next_s, b_next_s;
    logic [16:0] sum_s;
    logic [31:0] mul_step_s;
    logic [7:0]  digit_char_s;
    logic [15:0] a_carry_s;

    assign a_next_s     = ({4'b0000, a_q} * 20'd10) + {16'h0000, key_digit_s};
    assign b_next_s     = ({4'b0000, b_q} * 20'd10) + {16'h0000, key_digit_s};
    assign sum_s        = {1'b0, a_q} + {1'b0, b_q};
    assign mul_step_s   = acc_q + (mplier_q[0] ? mcand_q : 32'h0000_0000);
    assign digit_char_s = CH_ZERO + {4'h0, key_digit_s};
    assign a_carry_s    = (result_q > MAX_16) ? MAX_16 : result_q;

    // Entry/compute FSM next state and datapath
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        input_val_d = input_val_q;
        op_char_d   = op_char_q;
        result_d    = result_q;
        calc_done_d = calc_done_q;
        busy_d      = busy_q;
        ovf_d       = ovf_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        iter_d      = iter_q;
        if (state_q == ST_CALC) begin
            if (op_char_q == CH_MUL) begin
                acc_d    = mul_step_s;
                mcand_d  = {mcand_q[30:0], 1'b0};
                mplier_d = {1'b0, mplier_q[15:1]};
                iter_d   = iter_q + 4'd1;
                if (iter_q == 4'd15) begin
                    busy_d      = 1'b0;
                    calc_done_d = 1'b1;
                    state_d     = ST_DONE;
                    if (mul_step_s[31:16] != 16'h0000) begin
                        result_d = 16'hFFFF;
                        ovf_d    = 1'b1;
                    end else begin
                        result_d = mul_step_s[15:0];
                        ovf_d    = 1'b0;
                    end
                end else begin
                    busy_d = 1'b1;
                end
            end else if (op_char_q == CH_SUB) begin
                busy_d      = 1'b0;
                calc_done_d = 1'b1;
                state_d     = ST_DONE;
                if (a_q >= b_q) begin
                    result_d = a_q - b_q;
                    ovf_d    = 1'b0;
                end else begin
                    result_d = 16'h0000;
                    ovf_d    = 1'b1;
                end
            end else begin
                busy_d      = 1'b0;
                calc_done_d = 1'b1;
                state_d     = ST_DONE;
                if (sum_s[16]) begin
                    result_d = 16'hFFFF;
                    ovf_d    = 1'b1;
                end else begin
                    result_d = sum_s[15:0];
                    ovf_d    = 1'b0;
                end
            end
        end else if (ok_s) begin
            if (key_is_clr_s) begin
                a_d         = 16'h0000;
                b_d         = 16'h0000;
                input_val_d = 8'h00;
                op_char_d   = 8'h00;
                result_d    = 16'h0000;
                calc_done_d = 1'b0;
                ovf_d       = 1'b0;
                state_d     = ST_ENTER_A;
            end else begin
                case (state_q)
                    ST_ENTER_A: begin
                        if (key_is_digit_s) begin
                            if (a_next_s <= MAX_W) begin
                                a_d         = a_next_s[15:0];
                                input_val_d = digit_char_s;
                            end else begin
                                a_d = a_q;
                            end
                        end else if (key_is_op_s) begin
                            op_char_d = key_op_s;
                            state_d   = ST_OP;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    ST_OP: begin
                        if (key_is_digit_s) begin
                            b_d         = {12'h000, key_digit_s};
                            input_val_d = digit_char_s;
                            state_d     = ST_ENTER_B;
                        end else if (key_is_op_s) begin
                            op_char_d = key_op_s;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    ST_ENTER_B: begin
                        if (key_is_digit_s) begin
                            if (b_next_s <= MAX_W) begin
                                b_d         = b_next_s[15:0];
                                input_val_d = digit_char_s;
                            end else begin
                                b_d = b_q;
                            end
                        end else if (key_is_eq_s) begin
                            state_d  = ST_CALC;
                            busy_d   = 1'b1;
                            acc_d    = 32'h0000_0000;
                            mcand_d  = {16'h0000, a_q};
                            mplier_d = b_q;
                            iter_d   = 4'd0;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    ST_DONE: begin
                        if (key_is_digit_s) begin
                            a_d         = {12'h000, key_digit_s};
                            b_d         = 16'h0000;
                            input_val_d = digit_char_s;
                            op_char_d   = 8'h00;
                            result_d    = 16'h0000;
                            calc_done_d = 1'b0;
                            ovf_d       = 1'b0;
                            state_d     = ST_ENTER_A;
                        end else if (key_is_op_s) begin
                            a_d         = a_carry_s;
                            b_d         = 16'h0000;
                            op_char_d   = key_op_s;
                            calc_done_d = 1'b0;
                            ovf_d       = 1'b0;
                            state_d     = ST_OP;
                        end else begin
                            state_d = state_q;
                        end
                    end
                    default: state_d = ST_ENTER_A;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // FSM and datapath registers
    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_ENTER_A;
            a_q         <= 16'h0000;
            b_q         <= 16'h0000;
            input_val_q <= 8'h00;
            op_char_q   <= 8'h00;
            result_q    <= 16'h0000;
            calc_done_q <= 1'b0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            acc_q       <= 32'h0000_0000;
            mcand_q     <= 32'h0000_0000;
            mplier_q    <= 16'h0000;
            iter_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            input_val_q <= input_val_d;
            op_char_q   <= op_char_d;
            result_q    <= result_d;
            calc_done_q <= calc_done_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            iter_q      <= iter_d;
        end
    end

    assign cursor_x  = {2'b00, cur_x_q};
    assign cursor_y  = {2'b00, cur_y_q};
    assign input_val = input_val_q;
    assign op_char   = op_char_q;
    assign result    = result_q;
    assign calc_done = calc_done_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_calc_ctrl.sv
// Self-checking bench for calc_ctrl: keypad vector table with a result scoreboard plus
// hand-written timing, priority, reset-abort and (with CALC_DEBOUNCE_EN) debounce sequences.
module tb_calc_ctrl;

    localparam int DEB = 8;
`ifdef CALC_DEBOUNCE_EN
    localparam int HOLD = 12;
    localparam int GAP  = 12;
    localparam int PRE  = 3 + DEB;
`else
    localparam int HOLD = 2;
    localparam int GAP  = 3;
    localparam int PRE  = 3;
`endif
    localparam logic [4:0] M_OK    = 5'b10000;
    localparam logic [4:0] M_UP    = 5'b01000;
    localparam logic [4:0] M_DOWN  = 5'b00100;
    localparam logic [4:0] M_LEFT  = 5'b00010;
    localparam logic [4:0] M_RIGHT = 5'b00001;
    localparam int NV = 14;

    logic        clk_in = 1'b0;
    logic        sys_rst_n;
    logic        btn_up, btn_down, btn_left, btn_right, btn_ok;
    logic [3:0]  cursor_x, cursor_y;
    logic [7:0]  input_val, op_char;
    logic [15:0] result;
    logic        calc_done, busy, ovf;

    calc_ctrl #(.DEBOUNCE_CYCLES(DEB), .MAX_OPERAND(9999)) dut (
        .clk_in(clk_in), .sys_rst_n(sys_rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_ok(btn_ok),
        .cursor_x(cursor_x), .cursor_y(cursor_y), .input_val(input_val),
        .op_char(op_char), .result(result), .calc_done(calc_done),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [7:0]  iv;
        logic [7:0]  op;
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [127:0] keys;
        exp_t         e;
    } vec_t;

    exp_t sb_q[$];
    vec_t vecs[NV];
    int   n_pass  = 0;
    int   n_total = 0;
    int   cx = 0;
    int   cy = 0;

    function automatic vec_t mk(input logic [127:0] k, input logic [7:0] iv, input logic [7:0] op,
                                input logic [15:0] res, input logic ov);
        vec_t v;
        v.keys  = k;
        v.e.iv  = iv;
        v.e.op  = op;
        v.e.res = res;
        v.e.ovf = ov;
        return v;
    endfunction

    function automatic exp_t mke(input logic [7:0] iv, input logic [7:0] op,
                                 input logic [15:0] res, input logic ov);
        exp_t e;
        e.iv  = iv;
        e.op  = op;
        e.res = res;
        e.ovf = ov;
        return e;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic drive(input logic [4:0] m);
        {btn_ok, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    task automatic press(input logic [4:0] m);
        drive(m);
        repeat (HOLD) @(negedge clk_in);
        drive(5'b00000);
        repeat (GAP) @(negedge clk_in);
    endtask

    task automatic goto_rc(input int r, input int c);
        while (cx != c) begin press(M_RIGHT); cx = (cx + 1) % 4; end
        while (cy != r) begin press(M_DOWN);  cy = (cy + 1) % 4; end
    endtask

    task automatic key_pos(input logic [7:0] ch, output int r, output int c);
        case (ch)
            "1": begin r = 0; c = 0; end
            "2": begin r = 0; c = 1; end
            "3": begin r = 0; c = 2; end
            "+": begin r = 0; c = 3; end
            "4": begin r = 1; c = 0; end
            "5": begin r = 1; c = 1; end
            "6": begin r = 1; c = 2; end
            "-": begin r = 1; c = 3; end
            "7": begin r = 2; c = 0; end
            "8": begin r = 2; c = 1; end
            "9": begin r = 2; c = 2; end
            "*": begin r = 2; c = 3; end
            "C": begin r = 3; c = 0; end
            "0": begin r = 3; c = 1; end
            "=": begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end
        endcase
    endtask

    task automatic key(input logic [7:0] ch);
        int r, c;
        key_pos(ch, r, c);
        goto_rc(r, c);
        press(M_OK);
    endtask

    task automatic keys_only(input logic [127:0] k);
        for (int i = 15; i >= 0; i--)
            if (k[i*8 +: 8] != 8'h00) key(k[i*8 +: 8]);
    endtask

    task automatic run(input string tag, input logic [127:0] k, input exp_t e);
        exp_t got;
        sb_q.push_back(e);
        keys_only(k);
        for (int w = 0; w < 60 && calc_done !== 1'b1; w++) @(negedge clk_in);
        got = sb_q.pop_front();
        check({tag, " calc_done"}, 32'(calc_done), 32'd1);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " input_val"}, 32'(input_val), 32'(got.iv));
        check({tag, " op_char"},   32'(op_char),   32'(got.op));
        check({tag, " result"},    32'(result),    32'(got.res));
        check({tag, " ovf"},       32'(ovf),       32'(got.ovf));
    endtask

    task automatic timed_eq(input string tag, input int exp_done, input int exp_busy,
                            input logic [15:0] exp_res);
        int done_at  = -1;
        int busy_cnt = 0;
        goto_rc(3, 2);
        drive(M_OK);
        for (int k = 1; k <= PRE + 24; k++) begin
            @(negedge clk_in);
            if (k == HOLD) drive(5'b00000);
            if (busy === 1'b1) busy_cnt++;
            if (calc_done === 1'b1 && done_at < 0) done_at = k;
        end
        check({tag, " done edge"},   32'(done_at),  32'(exp_done));
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " result"},      32'(result),   32'(exp_res));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " cursor_x"},  32'(cursor_x),  32'd0);
        check({tag, " cursor_y"},  32'(cursor_y),  32'd0);
        check({tag, " input_val"}, 32'(input_val), 32'd0);
        check({tag, " op_char"},   32'(op_char),   32'd0);
        check({tag, " result"},    32'(result),    32'd0);
        check({tag, " calc_done"}, 32'(calc_done), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " ovf"},       32'(ovf),       32'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(128'("C12+34="),       "4", "+", 16'd46,    1'b0);
        vecs[1]  = mk(128'("C99999*99999="), "9", "*", 16'hFFFF,  1'b1);
        vecs[2]  = mk(128'("C3-7="),         "7", "-", 16'd0,     1'b1);
        vecs[3]  = mk(128'("C25*4="),        "4", "*", 16'd100,   1'b0);
        vecs[4]  = mk(128'("C100-1="),       "1", "-", 16'd99,    1'b0);
        vecs[5]  = mk(128'("C12*+5="),       "5", "+", 16'd17,    1'b0);
        vecs[6]  = mk(128'("C5=+3="),        "3", "+", 16'd8,     1'b0);
        vecs[7]  = mk(128'("C7+2+3="),       "3", "+", 16'd30,    1'b0);
        vecs[8]  = mk(128'("C255*257="),     "7", "*", 16'd65535, 1'b0);
        vecs[9]  = mk(128'("C256*256="),     "6", "*", 16'hFFFF,  1'b1);
        vecs[10] = mk(128'("C99999+1="),     "1", "+", 16'd10000, 1'b0);
        vecs[11] = mk(128'("C1234+56789="),  "8", "+", 16'd6912,  1'b0);
        vecs[12] = mk(128'("C0*9="),         "9", "*", 16'd0,     1'b0);
        vecs[13] = mk(128'("C6-6="),         "6", "-", 16'd0,     1'b0);

        sys_rst_n = 1'b0;
        drive(5'b00000);
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        sys_rst_n = 1'b1;
        @(negedge clk_in);

        // cursor wrap-around
        repeat (5) press(M_RIGHT);
        check("right x5 cursor_x", 32'(cursor_x), 32'd1);
        check("right x5 cursor_y", 32'(cursor_y), 32'd0);
        repeat (2) press(M_LEFT);
        check("left x2 cursor_x", 32'(cursor_x), 32'd3);
        press(M_UP);
        check("up wrap cursor_y", 32'(cursor_y), 32'd3);
        press(M_DOWN);
        check("down wrap cursor_y", 32'(cursor_y), 32'd0);
        cx = 3;
        cy = 0;

        for (int i = 0; i < NV; i++)
            run($sformatf("vec%0d", i), vecs[i].keys, vecs[i].e);

        // ok and right in the same cycle: only ok acts
        key("C");
        goto_rc(1, 1);
        press(M_OK | M_RIGHT);
        check("same-cycle input_val", 32'(input_val), 32'h35);
        check("same-cycle cursor_x",  32'(cursor_x),  32'd1);
        check("same-cycle cursor_y",  32'(cursor_y),  32'd1);

        // chaining from DONE
        run("neg", 128'("C3-7="), mke("7", "-", 16'd0, 1'b1));
        key("+");
        check("done-op op_char",   32'(op_char),   32'h2B);
        check("done-op calc_done", 32'(calc_done), 32'd0);
        check("done-op ovf",       32'(ovf),       32'd0);
        run("chain", 128'("5="), mke("5", "+", 16'd5, 1'b0));
        key("4");
        check("done-digit input_val", 32'(input_val), 32'h34);
        check("done-digit op_char",   32'(op_char),   32'd0);
        check("done-digit result",    32'(result),    32'd0);
        check("done-digit calc_done", 32'(calc_done), 32'd0);
        run("after-digit", 128'("+1="), mke("1", "+", 16'd5, 1'b0));
        run("big", 128'("C256*256="), mke("6", "*", 16'hFFFF, 1'b1));
        run("clamp-A", 128'("-1="), mke("1", "-", 16'd9998, 1'b0));

        // exact latency of = for add and multiply
        key("C");
        keys_only(128'("12+34"));
        timed_eq("add timing", PRE + 1, 1, 16'd46);
        key("C");
        keys_only(128'("12*34"));
        timed_eq("mul timing", PRE + 16, 16, 16'd408);

        // reset asserted during a multiply
        key("C");
        keys_only(128'("99*99"));
        goto_rc(3, 2);
        drive(M_OK);
        for (int k = 1; k <= PRE + 5; k++) begin
            @(negedge clk_in);
            if (k == HOLD) drive(5'b00000);
        end
        check("mid-mul busy", 32'(busy), 32'd1);
        sys_rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(negedge clk_in);
        sys_rst_n = 1'b1;
        cx = 0;
        cy = 0;
        @(negedge clk_in);
        run("post-reset", 128'("7+1="), mke("1", "+", 16'd8, 1'b0));

`ifdef CALC_DEBOUNCE_EN
        // glitch shorter than the debounce window is ignored, a long hold acts once
        key("C");
        goto_rc(0, 0);
        drive(M_OK);
        repeat (5) @(negedge clk_in);
        drive(5'b00000);
        repeat (20) @(negedge clk_in);
        check("glitch input_val", 32'(input_val), 32'd0);
        drive(M_OK);
        repeat (12) @(negedge clk_in);
        drive(5'b00000);
        repeat (20) @(negedge clk_in);
        check("held input_val", 32'(input_val), 32'h31);
        run("single action", 128'("+0="), mke("0", "+", 16'd1, 1'b0));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
